grf_wb_scheduler: RTL and testbench



---
 rtl/grf_wb_scheduler.sv | 106 ++++++++++
 tb/tb_grf_wb_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_scheduler.sv
// GRF write-port scheduler: merges W-stage writes with long-latency results through a
// one-entry hold buffer and keeps a pending scoreboard that stalls D on hazards.
module grf_wb_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_we,
  input  logic [4:0]  w_a3,
  input  logic [31:0] w_wd,
  input  logic [31:0] w_pc,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_rd,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_wd,
  input  logic [31:0] lu_pc,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [4:0]  d_rd,
  output logic        stall,
  output logic        busy,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);

  logic [31:0] pending_q, pending_d;
  logic        hold_valid_q, hold_valid_d;
  logic [4:0]  hold_rd_q, hold_rd_d;
  logic [31:0] hold_wd_q, hold_wd_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  logic w_port;
  logic drain;
  logic accept;

  always_comb begin
    w_port   = w_we && (w_a3 != 5'd0);
    // A W write to $0 leaves the port free, so the hold entry may drain that cycle.
    drain    = !reset && !w_port && hold_valid_q;
    lu_ready = !reset && !hold_valid_q;
    accept   = lu_valid && lu_ready;

    pending_d    = pending_q;
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_wd_d    = hold_wd_q;
    hold_pc_d    = hold_pc_q;

    if (drain) begin
      pending_d[hold_rd_q] = 1'b0;
      hold_valid_d         = 1'b0;
    end
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_rd_d    = lu_rd;
      hold_wd_d    = lu_wd;
      hold_pc_d    = lu_pc;
    end
    // Applied after the clear so a new issue to the draining register wins.
    if (lu_issue && (lu_issue_rd != 5'd0)) begin
      pending_d[lu_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    grf_we = 1'b0;
    grf_a3 = 5'd0;
    grf_wd = 32'd0;
    grf_pc = 32'd0;
    if (!reset) begin
      if (w_port) begin
        grf_we = 1'b1;
        grf_a3 = w_a3;
        grf_wd = w_wd;
        grf_pc = w_pc;
      end else if (hold_valid_q) begin
        grf_we = 1'b1;
        grf_a3 = hold_rd_q;
        grf_wd = hold_wd_q;
        grf_pc = hold_pc_q;
      end
    end
    stall = !reset && (pending_q[d_rs] || pending_q[d_rt] || pending_q[d_rd]);
    busy  = !reset && ((|pending_q) || hold_valid_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= 32'd0;
      hold_valid_q <= 1'b0;
      hold_rd_q    <= 5'd0;
      hold_wd_q    <= 32'd0;
      hold_pc_q    <= 32'd0;
    end else begin
      pending_q    <= pending_d;
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_wd_q    <= hold_wd_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

endmodule

// File: tb/tb_grf_wb_scheduler.sv
// Bench for grf_wb_scheduler: directed scenarios with literal expectations, then random
// traffic checked every cycle against a set/queue reference model.
module tb_grf_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we;
  logic [4:0]  w_a3;
  logic [31:0] w_wd, w_pc;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wd, lu_pc;
  logic [4:0]  d_rs, d_rt, d_rd;
  logic        stall, busy, grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] pc;
  } result_t;

  bit      pend[32];
  result_t hold[$];

  always #5 clk = ~clk;

  grf_wb_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .w_we        (w_we),
    .w_a3        (w_a3),
    .w_wd        (w_wd),
    .w_pc        (w_pc),
    .lu_issue    (lu_issue),
    .lu_issue_rd (lu_issue_rd),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_rd       (lu_rd),
    .lu_wd       (lu_wd),
    .lu_pc       (lu_pc),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_rd        (d_rd),
    .stall       (stall),
    .busy        (busy),
    .grf_we      (grf_we),
    .grf_a3      (grf_a3),
    .grf_wd      (grf_wd),
    .grf_pc      (grf_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; w_we = 1'b0; w_a3 = 5'd0; w_wd = 32'd0; w_pc = 32'd0;
    lu_issue = 1'b0; lu_issue_rd = 5'd0; lu_valid = 1'b0; lu_rd = 5'd0;
    lu_wd = 32'd0; lu_pc = 32'd0; d_rs = 5'd0; d_rt = 5'd0; d_rd = 5'd0;
  endtask

  // Expected outputs follow from the current model state and the applied inputs.
  task automatic settle();
    bit      e_stall, e_busy, e_we;
    result_t e;
    #3;
    e_stall = 1'b0;
    e_busy  = 1'b0;
    e_we    = 1'b0;
    e = '{rd: 5'd0, wd: 32'd0, pc: 32'd0};
    if (!reset) begin
      e_stall = (d_rs != 0 && pend[d_rs]) || (d_rt != 0 && pend[d_rt]) ||
                (d_rd != 0 && pend[d_rd]);
      e_busy = hold.size() > 0;
      foreach (pend[i]) if (pend[i]) e_busy = 1'b1;
      if (w_we && w_a3 != 0) begin
        e_we = 1'b1;
        e = '{rd: w_a3, wd: w_wd, pc: w_pc};
      end else if (hold.size() > 0) begin
        e_we = 1'b1;
        e = hold[0];
      end
    end
    chk("grf_we", 32'(grf_we), 32'(e_we));
    chk("lu_ready", 32'(lu_ready), 32'(!reset && hold.size() == 0));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("busy", 32'(busy), 32'(e_busy));
    if (!reset) begin
      chk("grf_a3", 32'(grf_a3), 32'(e.rd));
      chk("grf_wd", grf_wd, e.wd);
      chk("grf_pc", grf_pc, e.pc);
    end
  endtask

  task automatic advance();
    bit had_hold;
    if (reset) begin
      foreach (pend[i]) pend[i] = 1'b0;
      hold.delete();
    end else begin
      had_hold = hold.size() > 0;
      if (!(w_we && w_a3 != 0) && had_hold) begin
        pend[hold[0].rd] = 1'b0;
        void'(hold.pop_front());
      end
      if (lu_valid && !had_hold) hold.push_back('{rd: lu_rd, wd: lu_wd, pc: lu_pc});
      if (lu_issue && lu_issue_rd != 0) pend[lu_issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pq[$];
    idle();
    @(posedge clk);
    #1;

    // Reset with traffic present on the inputs.
    reset = 1'b1; lu_valid = 1'b1; w_we = 1'b1; w_a3 = 5'd5; lu_issue = 1'b1; lu_issue_rd = 5'd7;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rst_grf_we", 32'(grf_we), 32'd0);
      chk("rst_lu_ready", 32'(lu_ready), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      advance();
    end
    idle();
    settle();
    chk("post_rst_lu_ready", 32'(lu_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    advance();

    // W pass-through.
    w_we = 1'b1; w_a3 = 5'd5; w_wd = 32'h1234_5678; w_pc = 32'h100;
    settle();
    chk("w_grf_we", 32'(grf_we), 32'd1);
    chk("w_grf_a3", 32'(grf_a3), 32'd5);
    chk("w_grf_wd", grf_wd, 32'h1234_5678);
    advance();
    w_a3 = 5'd0;
    settle();
    chk("w_zero_grf_we", 32'(grf_we), 32'd0);
    advance();
    idle();

    // Scoreboard round trip on $8.
    lu_issue = 1'b1; lu_issue_rd = 5'd8;
    settle(); advance();
    idle(); d_rs = 5'd8;
    settle();
    chk("sb_stall_issued", 32'(stall), 32'd1);
    chk("sb_busy", 32'(busy), 32'd1);
    advance();
    lu_valid = 1'b1; lu_rd = 5'd8; lu_wd = 32'hCAFE; lu_pc = 32'h200;
    settle();
    chk("sb_lu_ready", 32'(lu_ready), 32'd1);
    advance();
    lu_valid = 1'b0;
    settle();
    chk("sb_grf_we", 32'(grf_we), 32'd1);
    chk("sb_grf_a3", 32'(grf_a3), 32'd8);
    chk("sb_grf_wd", grf_wd, 32'hCAFE);
    chk("sb_stall_write", 32'(stall), 32'd1);
    advance();
    settle();
    chk("sb_stall_clear", 32'(stall), 32'd0);
    chk("sb_busy_clear", 32'(busy), 32'd0);
    advance();
    idle();

    // Contention: hold for $9 waits behind three W writes to $3.
    lu_issue = 1'b1; lu_issue_rd = 5'd9;
    settle(); advance();
    idle(); lu_valid = 1'b1; lu_rd = 5'd9; lu_wd = 32'h9999; lu_pc = 32'h300;
    settle(); advance();
    idle(); w_we = 1'b1; w_a3 = 5'd3; w_wd = 32'h33; lu_valid = 1'b1; lu_rd = 5'd9; d_rs = 5'd9;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ct_grf_a3_w", 32'(grf_a3), 32'd3);
      chk("ct_lu_ready", 32'(lu_ready), 32'd0);
      chk("ct_stall", 32'(stall), 32'd1);
      advance();
    end
    w_we = 1'b0; lu_valid = 1'b0;
    settle();
    chk("ct_grf_a3_hold", 32'(grf_a3), 32'd9);
    chk("ct_grf_wd_hold", grf_wd, 32'h9999);
    chk("ct_stall_drain", 32'(stall), 32'd1);
    advance();
    settle();
    chk("ct_lu_ready_after", 32'(lu_ready), 32'd1);
    chk("ct_stall_after", 32'(stall), 32'd0);
    advance();
    idle();

    // Same-edge set and clear on $10.
    lu_issue = 1'b1; lu_issue_rd = 5'd10;
    settle(); advance();
    idle(); lu_valid = 1'b1; lu_rd = 5'd10; lu_wd = 32'hA;
    settle(); advance();
    idle(); lu_issue = 1'b1; lu_issue_rd = 5'd10;
    settle();
    chk("se_grf_a3", 32'(grf_a3), 32'd10);
    advance();
    idle(); d_rt = 5'd10;
    settle();
    chk("se_stall", 32'(stall), 32'd1);
    chk("se_busy", 32'(busy), 32'd1);
    advance();
    idle(); lu_valid = 1'b1; lu_rd = 5'd10;
    settle(); advance();
    idle();
    settle(); advance();

    // Zero register is never pending.
    lu_issue = 1'b1; lu_issue_rd = 5'd0;
    settle(); advance();
    idle();
    settle();
    chk("zr_stall", 32'(stall), 32'd0);
    chk("zr_busy", 32'(busy), 32'd0);
    advance();

    // Random traffic, including occasional mid-operation reset.
    for (int n = 0; n < 3000; n++) begin
      pq.delete();
      foreach (pend[i]) if (pend[i]) pq.push_back(i);
      reset       = ($urandom_range(99) == 0);
      w_we        = $urandom_range(1);
      w_a3        = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      w_wd        = $urandom;
      w_pc        = $urandom;
      lu_issue    = ($urandom_range(3) == 0);
      lu_issue_rd = 5'($urandom);
      lu_valid    = ($urandom_range(9) < 4);
      lu_rd       = (pq.size() > 0 && $urandom_range(7) != 0) ?
                    5'(pq[$urandom_range(pq.size() - 1)]) : 5'($urandom);
      lu_wd       = $urandom;
      lu_pc       = $urandom;
      d_rs        = 5'($urandom);
      d_rt        = (pq.size() > 0 && $urandom_range(1) == 1) ?
                    5'(pq[$urandom_range(pq.size() - 1)]) : 5'($urandom);
      d_rd        = 5'($urandom);
      settle();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
